// File: rtl/box_sprite_renderer.sv
// Pixel source for an 800x600 VGA pipeline: one solid box over a solid background,
// bouncing off the screen edges, with sync delayed to match the one-strobe colour latency.
module box_sprite_renderer #(
  parameter int          SCREEN_WIDTH   = 800,
  parameter int          SCREEN_HEIGHT  = 600,
  parameter int          BOX_W          = 64,
  parameter int          BOX_H          = 48,
  parameter int          INIT_X         = 250,
  parameter int          INIT_Y         = 200,
  parameter int          STEP           = 1,
  parameter int          FRAME_DIV      = 1,
  parameter logic [11:0] BOX_COLOR      = 12'hF00,
  parameter logic [11:0] BG_COLOR       = 12'h00F,
  parameter bit          VS_ACTIVE_HIGH = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic [10:0] pix_x,
  input  logic [10:0] pix_y,
  input  logic        pix_active,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        pause,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hs,
  output logic        vs,
  output logic [10:0] box_x,
  output logic [10:0] box_y
);

  localparam logic SYNC_ON  = VS_ACTIVE_HIGH;
  localparam logic SYNC_OFF = ~VS_ACTIVE_HIGH;

  typedef enum logic {POS, NEG} dir_t;

  dir_t        dir_x, dir_y;
  logic        vs_prev;
  logic [7:0]  frame_cnt;
  logic        frame_evt, update;
  logic        in_box;
  logic [11:0] color;
  logic [11:0] nx_x, nx_y;

  // Result packs {new direction (1 = NEG), new position}; sums are 12-bit so nothing wraps.
  function automatic logic [11:0] step_axis(input logic [10:0] pos, input dir_t dir,
                                            input logic [11:0] lim, input logic [11:0] size);
    logic [11:0] ahead;
    logic [11:0] res;
    ahead = {1'b0, pos} + size + 12'(STEP);
    if (dir == POS) begin
      if (ahead >= lim) res = {1'b1, 11'(lim - size)};
      else              res = {1'b0, pos + 11'(STEP)};
    end else begin
      if ({1'b0, pos} <= 12'(STEP)) res = {1'b0, 11'd0};
      else                          res = {1'b1, pos - 11'(STEP)};
    end
    return res;
  endfunction

  assign frame_evt = (vs_in == SYNC_ON) && (vs_prev != SYNC_ON);
  assign update    = frame_evt && !pause && (frame_cnt == 8'(FRAME_DIV - 1));
  assign nx_x      = step_axis(box_x, dir_x, 12'(SCREEN_WIDTH), 12'(BOX_W));
  assign nx_y      = step_axis(box_y, dir_y, 12'(SCREEN_HEIGHT), 12'(BOX_H));

  always_comb begin
    in_box = ({1'b0, pix_x} >= {1'b0, box_x}) &&
             ({1'b0, pix_x} <  {1'b0, box_x} + 12'(BOX_W)) &&
             ({1'b0, pix_y} >= {1'b0, box_y}) &&
             ({1'b0, pix_y} <  {1'b0, box_y} + 12'(BOX_H));
    if (!pix_active) color = 12'h000;
    else if (in_box) color = BOX_COLOR;
    else             color = BG_COLOR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r  <= 4'h0;
      g  <= 4'h0;
      b  <= 4'h0;
      hs <= SYNC_OFF;
      vs <= SYNC_OFF;
    end else if (pix_en) begin
      {r, g, b} <= color;
      hs        <= hs_in;
      vs        <= vs_in;
    end
  end

  // Position only moves on a frame event, i.e. inside vertical blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev   <= SYNC_OFF;
      frame_cnt <= 8'd0;
      box_x     <= 11'(INIT_X);
      box_y     <= 11'(INIT_Y);
      dir_x     <= POS;
      dir_y     <= POS;
    end else begin
      vs_prev <= vs_in;
      if (frame_evt && !pause)
        frame_cnt <= update ? 8'd0 : frame_cnt + 8'd1;
      if (update) begin
        box_x <= nx_x[10:0];
        dir_x <= dir_t'(nx_x[11]);
        box_y <= nx_y[10:0];
        dir_y <= dir_t'(nx_y[11]);
      end
    end
  end

endmodule
